// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the flushed pipeline registers.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_MISS_WAIT   = 2'd1,
    ST_MISS_RESUME = 2'd2
  } state_t;

  // Instruction loaded by a flushed pipeline register (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with synchronous active-low clear; wraps on overflow.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Per-stage enable/flush sequencing for load-use bubbles, D-cache miss stalls and
// branch flushes, with stall and flush performance counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MISS_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard,
  input  logic             hazard_ld,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             miss_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MISS_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MISS_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pend_flush;
  logic              br_flush;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    br_flush     = 1'b0;
    case (state)
      ST_RUN: begin
        if (hazard_ld) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          mem_wb_flush = 1'b1;
        end else if (hazard) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          br_flush    = 1'b1;
        end
      end
      ST_MISS_WAIT: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
        mem_wb_flush = 1'b1;
      end
      ST_MISS_RESUME: begin
        // Deferred branch flush and a fresh load-use bubble may coincide here.
        if (pend_flush) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          br_flush    = 1'b1;
        end
        if (hazard) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, mem_wb_flush}          = '1;
      br_flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      wait_cnt   <= '0;
      pend_flush <= 1'b0;
      miss_err   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard_ld) begin
            state      <= ST_MISS_WAIT;
            wait_cnt   <= '0;
            pend_flush <= branch_taken;
          end
        end
        ST_MISS_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (mem_ready) begin
            state <= ST_MISS_RESUME;
          end else if (wait_cnt == WAIT_LAST) begin
            // The miss is abandoned, so any deferred branch flush goes with it.
            miss_err   <= 1'b1;
            pend_flush <= 1'b0;
            state      <= ST_RUN;
          end
        end
        ST_MISS_RESUME: begin
          pend_flush <= 1'b0;
          state      <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en),
    .count (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed vector table, miss-timeout
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned MISS_TIMEOUT = 64;
  localparam int unsigned CNT_W        = 32;

  // Output bundle order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, mem_wb_fl}
  localparam logic [7:0] O_RESET  = 8'b00000_111;
  localparam logic [7:0] O_NORMAL = 8'b11111_000;
  localparam logic [7:0] O_LU     = 8'b00111_010;
  localparam logic [7:0] O_MISS   = 8'b00000_001;
  localparam logic [7:0] O_BR     = 8'b11111_110;

  logic clk = 1'b0;
  logic rst_n, hazard, hazard_ld, mem_ready, branch_taken;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, miss_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] outv;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MISS_TIMEOUT(MISS_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hazard       (hazard),
    .hazard_ld    (hazard_ld),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .miss_err     (miss_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  assign outv = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, mem_wb_flush};

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: miss progress as a count of completed wait cycles.
  bit          m_in_miss, m_resume, m_pend, m_err;
  int          m_waited;
  int unsigned m_stall, m_flush;

  function automatic logic [7:0] model_out(bit r, bit hz, bit ld, bit br);
    logic [7:0] o;
    if (!r) return O_RESET;
    if (m_in_miss) return O_MISS;
    if (m_resume) begin
      o = m_pend ? O_BR : O_NORMAL;
      if (hz) begin
        o[7:6] = 2'b00;
        o[1]   = 1'b1;
      end
      return o;
    end
    if (ld) return O_MISS;
    if (hz) return O_LU;
    if (br) return O_BR;
    return O_NORMAL;
  endfunction

  task automatic model_step(input bit r, input bit hz, input bit ld, input bit mr, input bit br);
    logic [7:0] o;
    o = model_out(r, hz, ld, br);
    if (!r) begin
      {m_in_miss, m_resume, m_pend, m_err} = '0;
      m_waited = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (!o[7]) m_stall++;
    if ((m_resume && m_pend) || (!m_in_miss && !m_resume && !ld && !hz && br)) m_flush++;
    if (m_in_miss) begin
      m_waited++;
      if (mr) begin
        m_in_miss = 0; m_resume = 1;
      end else if (m_waited == MISS_TIMEOUT) begin
        m_in_miss = 0; m_err = 1; m_pend = 0;
      end
    end else if (m_resume) begin
      m_resume = 0; m_pend = 0;
    end else if (ld) begin
      m_in_miss = 1; m_waited = 0; m_pend = br;
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are checked mid-cycle.
  task automatic drive_check(input bit r, input bit hz, input bit ld, input bit mr, input bit br);
    rst_n = r; hazard = hz; hazard_ld = ld; mem_ready = mr; branch_taken = br;
    #4;
    chk("model_outputs", 32'(outv), 32'(model_out(r, hz, ld, br)));
    chk("model_stall_cnt", stall_cnt, m_stall);
    chk("model_flush_cnt", flush_cnt, m_flush);
    chk("model_miss_err", 32'(miss_err), 32'(m_err));
  endtask

  task automatic advance();
    model_step(rst_n, hazard, hazard_ld, mem_ready, branch_taken);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit r, input bit hz, input bit ld, input bit mr, input bit br);
    drive_check(r, hz, ld, mr, br);
    advance();
  endtask

  typedef struct {
    bit         r, hz, ld, mr, br;
    logic [7:0] exp_o;
    int         exp_stall, exp_flush;
  } vec_t;

  vec_t vecs[21];

  initial begin
    rst_n = 1'b0; hazard = 1'b0; hazard_ld = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;

    //           r  hz ld mr br  outputs   stall flush
    vecs[0]  = '{0, 0, 1, 0, 1, O_RESET,  0,  0};
    vecs[1]  = '{0, 1, 0, 1, 0, O_RESET,  0,  0};
    vecs[2]  = '{0, 0, 0, 0, 0, O_RESET,  0,  0};
    vecs[3]  = '{1, 0, 0, 0, 0, O_NORMAL, 0,  0};
    vecs[4]  = '{1, 1, 0, 0, 0, O_LU,     0,  0};
    vecs[5]  = '{1, 0, 0, 0, 0, O_NORMAL, 1,  0};
    vecs[6]  = '{1, 0, 1, 0, 0, O_MISS,   1,  0};
    vecs[7]  = '{1, 0, 0, 0, 0, O_MISS,   2,  0};
    vecs[8]  = '{1, 0, 0, 0, 0, O_MISS,   3,  0};
    vecs[9]  = '{1, 0, 0, 0, 0, O_MISS,   4,  0};
    vecs[10] = '{1, 0, 0, 0, 0, O_MISS,   5,  0};
    vecs[11] = '{1, 0, 0, 1, 0, O_MISS,   6,  0};
    vecs[12] = '{1, 0, 0, 0, 0, O_NORMAL, 7,  0};
    vecs[13] = '{1, 0, 0, 0, 0, O_NORMAL, 7,  0};
    vecs[14] = '{1, 0, 0, 0, 1, O_BR,     7,  0};
    vecs[15] = '{1, 0, 1, 0, 1, O_MISS,   7,  1};
    vecs[16] = '{1, 0, 0, 0, 1, O_MISS,   8,  1};
    vecs[17] = '{1, 0, 0, 1, 0, O_MISS,   9,  1};
    vecs[18] = '{1, 0, 0, 0, 0, O_BR,     10, 1};
    vecs[19] = '{1, 0, 0, 0, 0, O_NORMAL, 10, 2};
    vecs[20] = '{1, 1, 0, 0, 1, O_LU,     10, 2};

    foreach (vecs[i]) begin
      drive_check(vecs[i].r, vecs[i].hz, vecs[i].ld, vecs[i].mr, vecs[i].br);
      chk($sformatf("vec%0d_outputs", i), 32'(outv), 32'(vecs[i].exp_o));
      chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, vecs[i].exp_stall);
      chk($sformatf("vec%0d_flush_cnt", i), flush_cnt, vecs[i].exp_flush);
      chk($sformatf("vec%0d_miss_err", i), 32'(miss_err), 32'd0);
      advance();
    end
    #4;
    chk("table_final_stall_cnt", stall_cnt, 32'd11);
    #1;

    // Miss timeout: 64 wait cycles with no refill.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < MISS_TIMEOUT - 1; i++) cyc(1, 0, 0, 0, 0);
    drive_check(1, 0, 0, 0, 0);
    chk("timeout_last_wait_outputs", 32'(outv), 32'(O_MISS));
    chk("timeout_last_wait_err", 32'(miss_err), 32'd0);
    advance();
    drive_check(1, 0, 0, 0, 0);
    chk("timeout_err_set", 32'(miss_err), 32'd1);
    chk("timeout_back_to_run", 32'(outv), 32'(O_NORMAL));
    chk("timeout_stall_cnt", stall_cnt, MISS_TIMEOUT + 1);
    advance();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    drive_check(1, 0, 0, 0, 0);
    chk("timeout_err_sticky", 32'(miss_err), 32'd1);
    advance();
    cyc(0, 0, 0, 0, 0);
    drive_check(1, 0, 0, 0, 0);
    chk("timeout_err_cleared_by_reset", 32'(miss_err), 32'd0);
    advance();

    // Refill on the final wait cycle beats the timeout; deferred branch flush proves resume.
    cyc(1, 0, 1, 0, 1);
    for (int i = 0; i < MISS_TIMEOUT - 1; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    drive_check(1, 0, 0, 0, 0);
    chk("race_resume_outputs", 32'(outv), 32'(O_BR));
    chk("race_no_err", 32'(miss_err), 32'd0);
    advance();
    drive_check(1, 0, 0, 0, 0);
    chk("race_run_outputs", 32'(outv), 32'(O_NORMAL));
    chk("race_flush_cnt", flush_cnt, 32'd1);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bit r, hz, ld, mr, br;
      r  = ($urandom_range(0, 99) != 0);
      hz = ($urandom_range(0, 5) == 0);
      ld = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 4) == 0);
      if (m_resume) begin
        br = 1'b0;
        if (m_pend) hz = 1'b0;
      end
      cyc(r, hz, ld, mr, br);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the hazard unit's `hazard` (load-use, cache hit) and `hazard_ld` (load-use or load, cache miss) flags, plus the branch resolution from EX.
- Drives the per-stage enable and flush controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Sequences the multi-cycle stall on a D-cache miss and defers branch flushes that arrive during a stall.
- Keeps stall and flush performance counters.

Parameters:
- MISS_TIMEOUT, 64, max cycles spent in MISS_WAIT before miss_err is raised and the FSM is forced back to RUN.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- hazard  in  1  load-use hazard, cache hit case (needs a 1-cycle bubble).
- hazard_ld  in  1  load hazard, cache miss case (needs a multi-cycle stall).
- mem_ready  in  1  D-cache refill complete pulse.
- branch_taken  in  1  taken branch or jump resolved in EX (branch && cmp).
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF_ID register enable.
- id_ex_en  out  1  ID_EX register enable.
- ex_mem_en  out  1  EX_MEM register enable.
- mem_wb_en  out  1  MEM_WB register enable.
- if_id_flush  out  1  IF_ID loads a NOP.
- id_ex_flush  out  1  ID_EX loads a NOP (bubble).
- mem_wb_flush  out  1  MEM_WB loads a NOP.
- miss_err  out  1  sticky miss-timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not in reset.
- flush_cnt  out  CNT_W  count of branch flushes applied.

Behaviour:
- Reset: while rst_n=0 at a clk edge, the following are cleared: state to RUN, the wait counter, pend_flush, miss_err, stall_cnt and flush_cnt.
- While rst_n=0, the outputs are combinationally overridden:
  - all *_en = 0;
  - if_id_flush = id_ex_flush = mem_wb_flush = 1.
- A reset asserted mid-miss abandons the miss; there is no resume.
- Outputs: combinational from the registered state and the current inputs (zero latency, so stalls take effect in the same cycle as the hazard). Counters and state are registered.
- FSM states: RUN, MISS_WAIT, MISS_RESUME.
- RUN, priority order (highest first):
  1. hazard_ld=1: all five enables = 0 and mem_wb_flush = 1; next state MISS_WAIT, wait counter = 0. A concurrent branch_taken sets pend_flush=1.
  2. hazard=1: pc_en = if_id_en = 0, id_ex_flush = 1, other enables = 1. branch_taken is ignored, because a load-use and a branch in EX cannot be on the same instruction path.
  3. branch_taken=1: all enables = 1, if_id_flush = id_ex_flush = 1, flush_cnt += 1.
  4. Otherwise: all enables = 1, no flushes.
- MISS_WAIT: same outputs as the RUN/hazard_ld case. Each cycle the wait counter += 1.
  - mem_ready=1: next state MISS_RESUME.
  - Else if wait counter == MISS_TIMEOUT-1: set miss_err; next state RUN.
  - mem_ready and the timeout in the same cycle: mem_ready wins, miss_err is not set.
- MISS_RESUME (1 cycle; the cache now hits):
  - all enables = 1, mem_wb_flush = 0;
  - if pend_flush=1: if_id_flush = id_ex_flush = 1, pend_flush cleared, flush_cnt += 1;
  - a hazard=1 in this cycle is handled exactly as in RUN;
  - next state RUN.
- Counters: stall_cnt increments on every non-reset cycle with pc_en=0. Both counters wrap modulo 2^CNT_W with no saturation.
- miss_err: cleared only by reset.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_RUN=2'd0, ST_MISS_WAIT=2'd1, ST_MISS_RESUME=2'd2;
  - a common NOP instruction constant 32'h0000_0013, which is used by the flushed pipeline registers, not by this block.
- One natural sub-module, perf_counter, instantiated twice:
  - inputs clk, rst_n, inc;
  - output count[CNT_W-1:0];
  - synchronous clear, wrap on overflow.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → all *_en=0, all flushes=1, stall_cnt=flush_cnt=0, miss_err=0. First cycle after release → all enables 1.
- Load-use hit: pulse hazard=1 for 1 cycle in RUN → that cycle pc_en=if_id_en=0 and id_ex_flush=1; next cycle all enables 1; stall_cnt=1.
- Miss: assert hazard_ld=1, then mem_ready on the 5th MISS_WAIT cycle.
  - Required: 6 cycles with all enables 0 and mem_wb_flush=1.
  - Then 1 MISS_RESUME cycle with all enables 1, then RUN.
  - stall_cnt=6.
- Branch during miss: hazard_ld=1 and branch_taken=1 in the same cycle → no flush during MISS_WAIT; in MISS_RESUME if_id_flush=id_ex_flush=1; flush_cnt=1.
- Timeout: MISS_TIMEOUT=64, hazard_ld=1 with no mem_ready → after 64 MISS_WAIT cycles miss_err=1 and state RUN. miss_err stays 1 until rst_n=0.
- Simultaneous mem_ready and timeout on cycle 63 → MISS_RESUME entered, miss_err=0.
